coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front end that produces the coin codes consumed by `vending_machine` on its `in[1:0]` port. Two raw coin-sensor lines (5-unit, 10-unit) are synchronised and debounced; each clean rising edge becomes one coin event, which is queued in a small FIFO. Coins are then emitted to the vending FSM as single-cycle codes, paced by a `hold` back-pressure input. It sits between the coin mechanism pins and `vending_machine`.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronised samples needed to change a debounced level (≥2)
- `FIFO_DEPTH`, 4, coin queue depth (power of two, ≥2)
- `clk` in 1: single system clock, rising edge
- `reset` in 1: asynchronous, active-low (asserted when 0)
- `coin5_raw` in 1: raw 5-unit sensor level, asynchronous to `clk`
- `coin10_raw` in 1: raw 10-unit sensor level, asynchronous to `clk`
- `hold` in 1: 1 = do not emit a coin this cycle
- `in` out 2: coin code to `vending_machine`: 00 none, 01 = 5, 10 = 10; 11 never driven
- `pending` out $clog2(FIFO_DEPTH)+1: number of queued coins
- `overflow` out 1: one-cycle pulse when a coin is dropped because the FIFO is full
- `jam` out 1: one-cycle pulse when both sensors produce an edge in the same cycle

## Operation
- Each sensor: 2-flop synchroniser, then debouncer. The debounced level flips only after the synchronised level differs from it for `DEBOUNCE_CYCLES` consecutive cycles; any agreeing sample resets the counter to 0. Falls are debounced identically, so a sensor must return low for `DEBOUNCE_CYCLES` cycles before another coin is accepted.
- Coin event: debounced 0→1 transition, detected against a registered copy of the level.
- Single event: push code (5 or 10) into the FIFO.
- Both events in the same cycle: neither pushed; `jam` pulses.
- FIFO full at push time with no pop that cycle: coin dropped, `overflow` pulses, contents unchanged. If a pop occurs in the same cycle, the pop frees a slot first and the push succeeds.
- Emit: when the FIFO is non-empty and `hold`=0, pop the head and register its code on `in` for exactly one cycle. Otherwise `in`=00 next cycle. Back-to-back coins are emitted on consecutive cycles with no idle gap.
- `hold` only blocks pops. It never drops or reorders coins; order is FIFO.
- `pending` is registered and reflects the count after that cycle's push and pop.

## Timing
- Reset values: `in`=00, `pending`=0, `overflow`=0, `jam`=0. Synchronisers, debounced levels, edge registers, and counters are all 0, and the FIFO is empty.
- Reset asserted mid-operation: queued coins are discarded immediately and `in` returns to 00 asynchronously.
- Sensor already high at reset release: it is counted as one coin after normal debounce.
- Latency, FIFO empty, `hold`=0: if edge k is the first to sample raw=1, then
  - synchroniser output is high after edge k+1;
  - debounced level is set at edge k+1+`DEBOUNCE_CYCLES`;
  - FIFO write occurs at the next edge;
  - `in` becomes valid after edge k+3+`DEBOUNCE_CYCLES`.
  - With the default of 4, the code appears 7 edges after first sampling and is held for one cycle.
- `hold` is sampled at the pop edge. Raising `hold` in cycle t means `in`=00 in cycle t+1.
- `overflow` and `jam` are registered pulses, asserted the cycle after the offending event.

## Structure
- Shared package `vend_pkg`:
  - coin-code constants `COIN_NONE`=2'b00, `COIN_5`=2'b01, `COIN_10`=2'b10;
  - `vending_machine` uses the same constants.
- Sub-module `coin_debounce`: synchroniser, debounce counter, and rising-edge detect, parameterised by `DEBOUNCE_CYCLES`. It is instantiated once per sensor.
- The FIFO is inline: a 1-bit-wide array (0 = 5, 1 = 10) with read/write pointers one bit wider than the index.

## Test plan
- Reset, then `coin5_raw` high for 10 cycles → after 7 edges `in`=01 for exactly one cycle, `pending` returns to 0, no further codes.
- `coin10_raw` glitch high for 3 cycles (< `DEBOUNCE_CYCLES`) → `in` stays 00, no pulses.
- Coins 5, 10, 5 with each sensor pulse separated, `hold`=1 throughout → `pending` reaches 3, `in`=00. Then `hold`=0 → `in` = 01, 10, 01 on three consecutive cycles.
- `hold`=1, push 5 coins with `FIFO_DEPTH`=4 → `pending`=4, one `overflow` pulse. Release `hold` → exactly 4 codes emitted, in order.
- Both raw sensors rise together → `jam` pulses once, `pending` stays 0, `in` stays 00.
- Three coins queued with `hold`=1; pull `reset` low for 1 cycle mid-queue → `in`=00 and `pending`=0 immediately; no stale coins after release.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_pkg : coin codes shared by coin_acceptor and vending_machine   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   // The FIFO stores one bit per coin: 0 = 5-unit, 1 = 10-unit.
   function automatic logic [1:0] coin_code(input logic is_ten);
      return is_ten ? COIN_10 : COIN_5;
   endfunction

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coin_debounce : 2-flop synchroniser, debounce counter, rise detect |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic rise_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic          level_q;
   logic          level_d;
   logic          prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q != level_q) begin
         if (cnt_q == LAST_COUNT) begin
            level_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= raw_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = level_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coin_acceptor : debounced coin sensors queued into a paced emitter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module coin_acceptor
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        coin5_raw,
   input  logic                        coin10_raw,
   input  logic                        hold,
   output logic [1:0]                  in,
   output logic [$clog2(FIFO_DEPTH):0] pending,
   output logic                        overflow,
   output logic                        jam
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic          rise5_w;
   logic          rise10_w;

   logic          mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   wr_ptr_d;
   logic [AW:0]   rd_ptr_q;
   logic [AW:0]   rd_ptr_d;
   logic [AW:0]   count_w;
   logic [AW:0]   pending_d;
   logic [AW:0]   pending_q;
   logic [1:0]    in_d;
   logic [1:0]    in_q;
   logic          overflow_d;
   logic          overflow_q;
   logic          jam_d;
   logic          jam_q;
   logic          empty_w;
   logic          full_w;
   logic          pop_w;
   logic          push_req_w;
   logic          push_w;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (coin5_raw),
      .rise_o (rise5_w)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (coin10_raw),
      .rise_o (rise10_w)
   );

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   always_comb begin
      count_w    = wr_ptr_q - rd_ptr_q;
      empty_w    = (count_w == '0);
      full_w     = (count_w == FULL_COUNT);
      pop_w      = ~empty_w & ~hold;
      push_req_w = rise5_w ^ rise10_w;
      push_w     = push_req_w & (~full_w | pop_w);
      jam_d      = rise5_w & rise10_w;
      overflow_d = push_req_w & full_w & ~pop_w;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pending_d  = count_w;
      in_d       = COIN_NONE;
      if (pop_w) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         pending_d = pending_d - 1'b1;
         in_d      = coin_code(mem_q[rd_ptr_q[AW-1:0]]);
      end
      if (push_w) begin
         wr_ptr_d  = wr_ptr_q + 1'b1;
         pending_d = pending_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_w) begin
         mem_q[wr_ptr_q[AW-1:0]] <= rise10_w;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pending_q  <= '0;
         in_q       <= COIN_NONE;
         overflow_q <= 1'b0;
         jam_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pending_q  <= pending_d;
         in_q       <= in_d;
         overflow_q <= overflow_d;
         jam_q      <= jam_d;
      end
   end

   assign in       = in_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign jam      = jam_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_coin_acceptor : randomized scoreboard bench for coin_acceptor    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_coin_acceptor;

   localparam int D     = 4;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic          clk        = 1'b0;
   logic          reset      = 1'b0;
   logic          coin5_raw  = 1'b0;
   logic          coin10_raw = 1'b0;
   logic          hold       = 1'b0;
   logic [1:0]    in;
   logic [PW-1:0] pending;
   logic          overflow;
   logic          jam;

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .coin5_raw  (coin5_raw),
      .coin10_raw (coin10_raw),
      .hold       (hold),
      .in         (in),
      .pending    (pending),
      .overflow   (overflow),
      .jam        (jam)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] code;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   hold_mode = 0;
   bit   ev5  [int];
   bit   ev10 [int];
   bit   model_q [$];
   exp_t exp_q [$];
   int   exp_pending = 0;
   bit   exp_ovf = 1'b0;
   bit   exp_jam = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      model_q.delete();
      exp_q.delete();
      ev5.delete();
      ev10.delete();
      exp_pending = 0;
      exp_ovf     = 1'b0;
      exp_jam     = 1'b0;
   endtask

   // Reference: each accepted coin reaches the queue at a fixed latency from
   // its first sampled edge; the queue is a plain FIFO of bounded depth.
   always @(posedge clk) begin
      bit   pop;
      bit   p5;
      bit   p10;
      bit   full;
      exp_t e;
      cyc++;
      if (!reset) begin
         model_clear();
      end else begin
         full    = (model_q.size() == DEPTH);
         pop     = (model_q.size() > 0) && !hold;
         p5      = ev5.exists(cyc);
         p10     = ev10.exists(cyc);
         exp_ovf = 1'b0;
         exp_jam = 1'b0;
         if (pop) begin
            e.cyc  = cyc;
            e.code = model_q[0] ? 2'b10 : 2'b01;
            exp_q.push_back(e);
            void'(model_q.pop_front());
         end
         if (p5 && p10) begin
            exp_jam = 1'b1;
         end else if (p5 || p10) begin
            if (full && !pop) exp_ovf = 1'b1;
            else              model_q.push_back(p10);
         end
         exp_pending = model_q.size();
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (in != 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL in_unexpected: got %0d expected none (cycle %0d)", in, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("in_code", int'(in), int'(e.code));
            chk("in_cycle", cyc, e.cyc);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL in_missing: got 0 expected %0d (cycle %0d)", e.code, e.cyc);
      end
      chk("pending", int'(pending), exp_pending);
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("jam", int'(jam), int'(exp_jam));
   end

   task automatic upd_hold();
      case (hold_mode)
         0:       hold = 1'b0;
         1:       hold = 1'b1;
         default: hold = ($urandom_range(0, 99) < 40);
      endcase
   endtask

   // A width of 0 leaves that sensor idle; widths >= D make a coin.
   task automatic pulse(input int w5, input int w10);
      int k;
      int mx;
      @(negedge clk);
      k = cyc + 1;
      if (w5 >= D)  ev5[k + D + 2]  = 1'b1;
      if (w10 >= D) ev10[k + D + 2] = 1'b1;
      coin5_raw  = (w5 > 0);
      coin10_raw = (w10 > 0);
      upd_hold();
      mx = (w5 > w10) ? w5 : w10;
      for (int i = 1; i <= mx; i++) begin
         @(negedge clk);
         if (i == w5)  coin5_raw  = 1'b0;
         if (i == w10) coin10_raw = 1'b0;
         upd_hold();
      end
      repeat (D + 2) begin
         @(negedge clk);
         upd_hold();
      end
   endtask

   task automatic do_reset(input bit high5);
      @(negedge clk);
      reset      = 1'b0;
      coin5_raw  = high5;
      coin10_raw = 1'b0;
      model_clear();
      #1;
      chk("rst_in", int'(in), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_jam", int'(jam), 0);
      @(negedge clk);
      reset = 1'b1;
      if (high5) begin
         ev5[cyc + 1 + D + 2] = 1'b1;
         repeat (D + 2) @(negedge clk);
         coin5_raw = 1'b0;
      end
      repeat (D + 3) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset(1'b0);

      hold_mode = 0;
      pulse(10, 0);
      pulse(0, 3);
      idle(6);

      hold_mode = 1;
      pulse(6, 0);
      pulse(0, 6);
      pulse(6, 0);
      idle(3);
      chk("pending_three", int'(pending), 3);
      hold_mode = 0;
      idle(8);

      hold_mode = 1;
      for (int i = 0; i < 5; i++) pulse((i % 2 == 0) ? 5 : 0, (i % 2 == 0) ? 0 : 5);
      idle(2);
      chk("pending_full", int'(pending), DEPTH);
      hold_mode = 0;
      idle(8);

      pulse(5, 5);
      idle(4);

      hold_mode = 1;
      pulse(5, 0);
      pulse(0, 5);
      pulse(5, 0);
      do_reset(1'b0);
      hold_mode = 0;
      idle(6);

      do_reset(1'b1);
      idle(6);

      for (int it = 0; it < 150; it++) begin
         int sel;
         int w;
         sel       = $urandom_range(0, 2);
         w         = $urandom_range(1, 8);
         hold_mode = $urandom_range(0, 2);
         case (sel)
            0:       pulse(w, 0);
            1:       pulse(0, w);
            default: pulse(w, $urandom_range(1, 8));
         endcase
      end

      hold_mode = 0;
      hold      = 1'b0;
      idle(20);
      chk("drain_expected", exp_q.size(), 0);
      chk("drain_model", model_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
